axi_lite_register_bank: RTL

Parametrised AXI-Lite slave exposing a bank of NUM_REGS control/status registers. Independent read and write state machines, byte-strobe writes, per-register read-only selection, and error responses for out-of-range or illegal accesses. Sits behind an interconnect port and feeds configuration registers to peripheral cores, returning their status words.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/axi_lite_register_bank_if.sv | 37 +++
 rtl/axi_lite_register_bank_addr_decoder.sv | 24 ++
 rtl/axi_lite_register_bank.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite register bank: response codes and FSM state encodings.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } write_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } read_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_register_bank_if.sv
// AXI-Lite bus bundle with master/slave views.
interface axi_lite_interface #(
  parameter int READ_ADDRESS_WIDTH  = 8,
  parameter int WRITE_ADDRESS_WIDTH = 8,
  parameter int READ_DATA_WIDTH     = 32,
  parameter int WRITE_DATA_WIDTH    = 32
);
  logic [WRITE_ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                      awprot;
  logic                            awvalid;
  logic                            awready;
  logic [WRITE_DATA_WIDTH-1:0]     wdata;
  logic [WRITE_DATA_WIDTH/8-1:0]   wstrb;
  logic                            wvalid;
  logic                            wready;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [READ_ADDRESS_WIDTH-1:0]   araddr;
  logic [2:0]                      arprot;
  logic                            arvalid;
  logic                            arready;
  logic [READ_DATA_WIDTH-1:0]      rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;

  modport Master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_register_bank_addr_decoder.sv
// Byte address -> register index, in-range and read-only flags.
module axi_lite_addr_decoder
  import axi_lite_pkg::*;
#(
  parameter int                  NUM_REGS   = 16,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  localparam int                 IDX_W      = idx_width(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  ro
);
  localparam int OFF = $clog2(DATA_WIDTH/8);

  logic [ADDR_WIDTH-1:0] full;

  assign full     = addr >> OFF;
  assign in_range = 32'(full) < NUM_REGS;
  assign idx      = full[IDX_W-1:0];
  assign ro       = in_range && RO_MASK[idx];
endmodule

// File: rtl/axi_lite_register_bank.sv
// AXI-Lite control/status register bank with independent read and write FSMs.
// Optional privilege check on awprot/arprot enabled by AXI_LITE_REGBANK_PROT_CHECK_EN.
module axi_lite_register_bank
  import axi_lite_pkg::*;
#(
  parameter int                             NUM_REGS    = 16,
  parameter int                             DATA_WIDTH  = 32,
  parameter int                             ADDR_WIDTH  = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  axi_lite_interface.Slave               bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int NB    = DATA_WIDTH/8;
  localparam int IDX_W = idx_width(NUM_REGS);

`ifdef AXI_LITE_REGBANK_PROT_CHECK_EN
  localparam bit PROT_CHECK = 1'b1;
`else
  localparam bit PROT_CHECK = 1'b0;
`endif

  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] bank_t;

  bank_t regs, status_v;
  assign status_v = status_in;
  assign ctrl_out = regs;

  // Holds the ready outputs low until the first edge after reset release.
  logic rdy_en;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;

  // ---------------- write path ----------------
  write_state_t          w_state, w_next;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  aw_priv_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;
  resp_t                 bresp_q, w_resp;
  logic                  aw_hs, w_hs, commit, do_write;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic                  c_priv;
  logic [DATA_WIDTH-1:0] c_data;
  logic [NB-1:0]         c_strb;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range, w_ro;

  assign bus.awready = rdy_en && (w_state == W_IDLE || w_state == W_HAVE_DATA);
  assign bus.wready  = rdy_en && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bresp   = bresp_q;
  assign aw_hs       = bus.awvalid && bus.awready;
  assign w_hs        = bus.wvalid && bus.wready;

  always_ff @(posedge clk or negedge reset)
    if (!reset) w_state <= W_IDLE;
    else        w_state <= w_next;

  // Commit operands come from the live bus or the latch, whichever half arrived last.
  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    c_addr = bus.awaddr;
    c_priv = bus.awprot[0];
    c_data = bus.wdata;
    c_strb = bus.wstrb;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (aw_hs) begin
          w_next = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_next = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        c_addr = aw_addr_q;
        c_priv = aw_priv_q;
        if (w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        c_data = w_data_q;
        c_strb = w_strb_q;
        if (aw_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP:  if (bus.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  axi_lite_addr_decoder #(
    .NUM_REGS(NUM_REGS), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RO_MASK(RO_MASK)
  ) u_wdec (
    .addr(c_addr), .idx(w_idx), .in_range(w_in_range), .ro(w_ro)
  );

  always_comb begin
    w_resp = OKAY;
    if (!w_in_range)               w_resp = DECERR;
    else if (PROT_CHECK && !c_priv) w_resp = SLVERR;
    else if (w_ro)                 w_resp = SLVERR;
  end

  assign do_write = commit && (w_resp == OKAY) && (|c_strb);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      aw_addr_q <= '0;
      aw_priv_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= OKAY;
      wr_pulse  <= '0;
      regs      <= bank_t'(RESET_VALUE);
    end else begin
      wr_pulse <= '0;
      if (aw_hs) begin
        aw_addr_q <= bus.awaddr;
        aw_priv_q <= bus.awprot[0];
      end
      if (w_hs) begin
        w_data_q <= bus.wdata;
        w_strb_q <= bus.wstrb;
      end
      if (commit) bresp_q <= w_resp;
      if (do_write) begin
        wr_pulse[w_idx] <= 1'b1;
        for (int k = 0; k < NB; k++)
          if (c_strb[k]) regs[w_idx][8*k +: 8] <= c_data[8*k +: 8];
      end
    end

  // ---------------- read path ----------------
  read_state_t           r_state, r_next;
  resp_t                 rresp_q, r_resp;
  logic [DATA_WIDTH-1:0] rdata_q, r_data;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_in_range, r_ro, ar_hs;

  assign bus.arready = rdy_en && (r_state == R_IDLE);
  assign bus.rvalid  = (r_state == R_DATA);
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign ar_hs       = bus.arvalid && bus.arready;

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (bus.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  axi_lite_addr_decoder #(
    .NUM_REGS(NUM_REGS), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RO_MASK(RO_MASK)
  ) u_rdec (
    .addr(bus.araddr), .idx(r_idx), .in_range(r_in_range), .ro(r_ro)
  );

  always_comb begin
    r_resp = OKAY;
    r_data = '0;
    if (!r_in_range)                     r_resp = DECERR;
    else if (PROT_CHECK && !bus.arprot[0]) r_resp = SLVERR;
    else                                 r_data = r_ro ? status_v[r_idx] : regs[r_idx];
  end

  // Sampled from the pre-edge register image, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rresp_q <= OKAY;
      rdata_q <= '0;
    end else if (ar_hs) begin
      rresp_q <= r_resp;
      rdata_q <= r_data;
    end
endmodule
